// File: rtl/prio_encoder_q.sv
// Registered N-input priority encoder with sticky request capture, fixed or
// round-robin selection, and a valid/ready output stage.
module prio_encoder_q #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         clr,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         coal
);

    logic [N-1:0] pend;
    logic [N-1:0] grant_oh;
    logic [N-1:0] pend_kept;
    logic [W-1:0] ptr;
    logic [W-1:0] sel;
    logic [W-1:0] sel_fixed;
    logic [W-1:0] sel_below;
    logic         found_below;
    logic         load;
    logic         grant;

    assign load  = !out_valid || out_ready;
    assign grant = load && (pend != '0);

    // Ascending scan: the last hit wins, giving the highest set index overall
    // and the highest set index strictly below the round-robin pointer.
    always_comb begin
        sel_fixed   = '0;
        sel_below   = '0;
        found_below = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                sel_fixed = W'(i);
            end
            if (pend[i] && (W'(i) < ptr)) begin
                sel_below   = W'(i);
                found_below = 1'b1;
            end
        end
        sel = (mode && found_below) ? sel_below : sel_fixed;
    end

    assign grant_oh  = grant ? (N'(1) << sel) : '0;
    assign pend_kept = pend & ~grant_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
            coal      <= 1'b0;
        end else if (clr) begin
            pend      <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            coal      <= 1'b0;
        end else begin
            // A request on the bit being granted is fresh, so it is excluded from coal.
            coal <= |(req & pend_kept);
            if (grant) begin
                out_idx   <= sel;
                out_valid <= 1'b1;
                ptr       <= sel;
                pend      <= pend_kept | req;
            end else if (load) begin
                out_valid <= 1'b0;
                pend      <= req;
            end else begin
                pend <= pend | req;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed self-checking bench for prio_encoder_q (N = 8): reset, fixed drain,
// backpressure, round-robin vs fixed, coalescing, flush and async reset.
module tb_prio_encoder_q;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       mode;
    logic       clr;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       coal;

    int checks;
    int failures;

    prio_encoder_q #(.N(8), .W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mode     (mode),
        .clr      (clr),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .coal     (coal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req = '0; mode = 1'b0; clr = 1'b0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req = 8'($urandom);
            out_ready = 1'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b0 || out_idx !== 3'd0 || coal !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold got v=%b idx=%0d coal=%b expected v=0 idx=0 coal=0", out_valid, out_idx, coal);
            end
        end
        req = '0; out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_idx !== 3'd0 || coal !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_release got v=%b idx=%0d coal=%b expected v=0 idx=0 coal=0", out_valid, out_idx, coal);
            end
        end
    endtask

    task automatic test_fixed_drain();
        logic [2:0] exp_idx [3] = '{3'd5, 3'd3, 3'd1};
        reset_dut();
        mode = 1'b0; out_ready = 1'b1;
        req = 8'b0010_1010;
        step();
        req = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_latency got v=%b expected v=0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) begin
                failures++;
                $display("[TB] FAIL drain_grant%0d got v=%b idx=%0d expected v=1 idx=%0d", i, out_valid, out_idx, exp_idx[i]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        mode = 1'b0; out_ready = 1'b0;
        req = 8'b0010_1010;
        step();
        req = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d got v=%b idx=%0d expected v=1 idx=5", i, out_valid, out_idx);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
            failures++;
            $display("[TB] FAIL bp_second got v=%b idx=%0d expected v=1 idx=3", out_valid, out_idx);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd1) begin
            failures++;
            $display("[TB] FAIL bp_third got v=%b idx=%0d expected v=1 idx=1", out_valid, out_idx);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_empty got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rr [4] = '{3'd7, 3'd0, 3'd7, 3'd0};
        reset_dut();
        mode = 1'b1; out_ready = 1'b1;
        req = 8'b1000_0001;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_rr[i]) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d got v=%b idx=%0d expected v=1 idx=%0d", i, out_valid, out_idx, exp_rr[i]);
            end
        end
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
                failures++;
                $display("[TB] FAIL fixed_starve%0d got v=%b idx=%0d expected v=1 idx=7", i, out_valid, out_idx);
            end
        end
        req = '0;
    endtask

    task automatic test_coalesce();
        reset_dut();
        mode = 1'b0; out_ready = 1'b0;
        req = 8'b0000_1000;
        step();
        req = '0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
            failures++;
            $display("[TB] FAIL coal_first got v=%b idx=%0d expected v=1 idx=3", out_valid, out_idx);
        end
        req = 8'b0000_0100;
        step();
        checks++;
        if (coal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coal_new got coal=%b expected 0", coal);
        end
        step();
        req = '0;
        checks++;
        if (coal !== 1'b1) begin
            failures++;
            $display("[TB] FAIL coal_hit got coal=%b expected 1", coal);
        end
        step();
        checks++;
        if (coal !== 1'b0 || out_idx !== 3'd3 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL coal_pulse got coal=%b idx=%0d v=%b expected coal=0 idx=3 v=1", coal, out_idx, out_valid);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
            failures++;
            $display("[TB] FAIL coal_grant got v=%b idx=%0d expected v=1 idx=2", out_valid, out_idx);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coal_once got v=%b expected v=0", out_valid);
        end
    endtask

    // Builds pend = F0 with index 7 sitting valid in the output stage.
    task automatic load_f0();
        reset_dut();
        mode = 1'b0; out_ready = 1'b0;
        req = 8'hF0;
        step();
        req = '0;
        step();
        req = 8'h80;
        step();
        req = '0;
    endtask

    task automatic test_flush();
        load_f0();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
            failures++;
            $display("[TB] FAIL flush_setup got v=%b idx=%0d expected v=1 idx=7", out_valid, out_idx);
        end
        clr = 1'b1;
        req = 8'h01;
        step();
        clr = 1'b0;
        req = '0;
        checks++;
        if (out_valid !== 1'b0 || coal !== 1'b0 || out_idx !== 3'd7) begin
            failures++;
            $display("[TB] FAIL flush_clear got v=%b coal=%b idx=%0d expected v=0 coal=0 idx=7", out_valid, coal, out_idx);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flush_drained%0d got v=%b expected v=0", i, out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        load_f0();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || coal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_clear got v=%b idx=%0d coal=%b expected v=0 idx=0 coal=0", out_valid, out_idx, coal);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL async_drained%0d got v=%b expected v=0", i, out_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; req = '0; mode = 1'b0; clr = 1'b0; out_ready = 1'b0;
        test_reset();
        test_fixed_drain();
        test_backpressure();
        test_round_robin();
        test_coalesce();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
